// File: rtl/sub_pkg.sv
// Shared constants and the per-stage register bundle for the borrow-lookahead
// subtractor. Stage fields are sized to SUB_MAX_W so any legal WIDTH fits;
// bits above WIDTH are tied to zero and fall away in synthesis.
package sub_pkg;

    localparam int SUB_WIDTH = 8;   // default operand width
    localparam int SUB_CHUNK = 4;   // default bits resolved per stage
    localparam int SUB_MAX_W = 64;  // widest operand the stage bundle can carry

    // One pipeline stage: valid, chunk borrow-out, difference bits resolved so
    // far (low end), and the operands carried for the chunks still to come.
    typedef struct packed {
        logic                 vld;
        logic                 bor;
        logic [SUB_MAX_W-1:0] diff;
        logic [SUB_MAX_W-1:0] a;
        logic [SUB_MAX_W-1:0] b;
    } stage_reg_t;

endpackage

// File: rtl/borrow_lookahead_chunk.sv
// CHUNK-bit combinational borrow-lookahead subtractor slice.
// Every internal borrow is expanded as a flat sum of products over the
// generate/propagate terms rather than rippled bit by bit.
module borrow_lookahead_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   bor;

    // Generate-borrow where A=0,B=1; propagate where the bits are equal.
    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Lookahead: bor[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]bin.
    always_comb begin
        logic term;
        logic pchain;
        bor    = '0;
        bor[0] = bin;
        for (int i = 0; i < CHUNK; i++) begin
            term   = g[i];
            pchain = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term   = term | (pchain & g[j]);
                pchain = pchain & p[j];
            end
            bor[i+1] = term | (pchain & bin);
        end
    end

    assign d    = a ^ b ^ bor[CHUNK-1:0];
    assign bout = bor[CHUNK];

endmodule

// File: rtl/borrow_lookahead_subtractor.sv
// Pipelined unsigned subtractor: o_result = {A<B, (A-B) mod 2^WIDTH}.
// Chunk k is resolved in stage k; latency is WIDTH/CHUNK cycles with one
// operation per cycle throughput. A stalled output freezes the whole pipe.
// Optional: define SUB_OVERFLOW_EN to add o_ovf (two's-complement overflow).
// WIDTH must be a multiple of CHUNK, at least 2 and at most SUB_MAX_W.
module borrow_lookahead_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int CHUNK = SUB_CHUNK
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_min,
    input  logic [WIDTH-1:0] i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result
`ifdef SUB_OVERFLOW_EN
   ,output logic             o_ovf
`endif
);

    localparam int STAGES = WIDTH / CHUNK;

    logic [STAGES:0] vld_pipe;
    logic            adv;
    stage_reg_t      last_q;

    // Everything advances unless a finished result is waiting on downstream.
    assign adv      = !(o_valid && !i_ready);
    assign o_ready  = adv;
    assign o_valid  = vld_pipe[STAGES];
    assign vld_pipe[0] = i_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_reg_t       src;
        stage_reg_t       nxt;
        stage_reg_t       q;
        logic [CHUNK-1:0] d;
        logic             bout;

        if (k == 0) begin : g_first
            // Stage 0 works straight off the input operands, no borrow-in.
            always_comb begin
                src              = '0;
                src.vld          = i_valid;
                src.a[WIDTH-1:0] = i_min;
                src.b[WIDTH-1:0] = i_sub;
            end
        end else begin : g_next
            assign src = g_stage[k-1].q;
        end

        borrow_lookahead_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a    (src.a[k*CHUNK +: CHUNK]),
            .b    (src.b[k*CHUNK +: CHUNK]),
            .bin  (src.bor),
            .d    (d),
            .bout (bout)
        );

        // Merge this chunk's difference and borrow-out into the carried bundle.
        always_comb begin
            nxt                        = src;
            nxt.diff[k*CHUNK +: CHUNK] = d;
            nxt.bor                    = bout;
        end

        // Stage register: cleared on reset, frozen while the output stalls.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                q <= '0;
            end else if (adv) begin
                q <= nxt;
            end
        end

        assign vld_pipe[k+1] = q.vld;

        if (k == STAGES - 1) begin : g_last
            assign last_q = q;
        end
    end

    assign o_result = {last_q.bor, last_q.diff[WIDTH-1:0]};

`ifdef SUB_OVERFLOW_EN
    // Overflow when operand signs differ and the result sign differs from A.
    assign o_ovf = (last_q.a[WIDTH-1] ^ last_q.b[WIDTH-1])
                 & (last_q.diff[WIDTH-1] ^ last_q.a[WIDTH-1]);
`endif

    // Operand bits of the final stage and unused high bundle bits are only
    // needed for overflow; keep them visibly consumed in every build.
    logic unused_tail;
    assign unused_tail = ^last_q;

endmodule

// File: tb/tb_borrow_lookahead_subtractor.sv
// Directed + short random bench for borrow_lookahead_subtractor (WIDTH=8,
// CHUNK=4). Expected results are pushed when an operand pair is accepted and
// popped when the DUT hands a result downstream.
module tb_borrow_lookahead_subtractor;

    localparam int W = 8;

    logic         i_clk;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_min;
    logic [W-1:0] i_sub;
    logic         o_valid;
    logic         i_ready;
    logic [W:0]   o_result;
`ifdef SUB_OVERFLOW_EN
    logic         o_ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [W+1:0] sb[$];   // {ovf, borrow, diff}

    borrow_lookahead_subtractor #(.WIDTH(W), .CHUNK(4)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_min    (i_min),
        .i_sub    (i_sub),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
`ifdef SUB_OVERFLOW_EN
       ,.o_ovf    (o_ovf)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: 9-bit subtraction gives borrow in bit 8 directly.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] r;
        logic       ovf;
        r   = {1'b0, a} - {1'b0, b};
        ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        return {ovf, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: settle, score the output/input handshakes, then advance to
    // the next falling edge where the caller sets up the following cycle.
    task automatic step();
        logic [W+1:0] e;
        #1;
        if (o_valid && i_ready) begin
            check("sb_nonempty", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("result", o_result, e[W:0]);
`ifdef SUB_OVERFLOW_EN
                check("ovf", o_ovf, e[W+1]);
`endif
            end
        end
        if (i_valid && o_ready) sb.push_back(model(i_min, i_sub));
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        i_valid = v;
        i_min   = a;
        i_sub   = b;
    endtask

    task automatic drain();
        int n = 0;
        drive(1'b0, '0, '0);
        i_ready = 1'b1;
        while (sb.size() > 0 && n < 20) begin
            step();
            n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        logic [W-1:0] sa [6];
        logic [W-1:0] sb_op [6];
        logic [W:0]   held;
        int           idx;
        int           acc;

        i_rst   = 1'b1;
        i_ready = 1'b1;
        drive(1'b0, '0, '0);

        // Reset state, including o_ready asserted during reset.
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_result", o_result, 0);
        check("rst_ready", o_ready, 1);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("post_rst_ready", o_ready, 1);
        check("post_rst_valid", o_valid, 0);

        // 0x05 - 0x03: visible exactly two edges after accept.
        @(negedge i_clk);
        drive(1'b1, 8'h05, 8'h03);
        step();
        drive(1'b0, '0, '0);
        #1;
        check("lat_edge1_valid", o_valid, 0);
        step();
        #1;
        check("lat_edge2_valid", o_valid, 1);
        check("lat_edge2_result", o_result, 9'h002);
        drain();

        // Back-to-back boundary cases, including borrow across the chunk edge.
        drive(1'b1, 8'h03, 8'h05); step();
        drive(1'b1, 8'h00, 8'hFF); step();
        drive(1'b1, 8'hFF, 8'hFF); step();
        drive(1'b1, 8'h10, 8'h01); step();
        drive(1'b1, 8'h80, 8'h01); step();
        drive(1'b1, 8'h7F, 8'hFF); step();
        drain();

        // Six-op stream with downstream stalled for three cycles mid-stream.
        sa    = '{8'h11, 8'h22, 8'h05, 8'hA0, 8'h3C, 8'h00};
        sb_op = '{8'h01, 8'h33, 8'h05, 8'h0F, 8'hC3, 8'h01};
        idx  = 0;
        held = '0;
        for (int cyc = 0; cyc < 30 && (idx < 6 || sb.size() > 0); cyc++) begin
            i_ready = !(cyc >= 3 && cyc < 6);
            if (idx < 6) drive(1'b1, sa[idx], sb_op[idx]);
            else         drive(1'b0, '0, '0);
            #1;
            if (cyc == 3) begin
                check("stall_valid", o_valid, 1);
                held = o_result;
            end
            if (cyc >= 3 && cyc < 6) begin
                check("stall_ready", o_ready, 0);
                check("stall_hold", o_result, held);
            end
            if (i_valid && o_ready) idx++;
            step();
        end
        check("stream_accepted", idx, 6);
        drain();

        // Reset with two operations in flight: drops them at once.
        drive(1'b1, 8'h44, 8'h11); step();
        drive(1'b1, 8'h55, 8'h66); step();
        drive(1'b0, '0, '0);
        i_rst = 1'b1;
        #1;
        check("midrst_valid", o_valid, 0);
        check("midrst_result", o_result, 0);
        check("midrst_ready", o_ready, 1);
        sb.delete();
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_stale", o_valid, 0);
        end
        drive(1'b1, 8'h22, 8'h11); step();
        drain();

        // Random valid/ready pattern, scoreboard enforces order and count.
        acc = 0;
        for (int cyc = 0; cyc < 200 && acc < 20; cyc++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom));
            #1;
            if (i_valid && o_ready) acc++;
            step();
        end
        check("rand_accepted", acc, 20);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
